kiwi_axil_rd_arbiter: RTL and testbench

//  N-master to 1-slave AXI-lite read-channel arbiter with round-robin grant and in-order multi-outstanding support.

---
 rtl/kiwi_axil_rd_arbiter.sv | 130 +++++++++++++
 tb/tb_kiwi_axil_rd_arbiter.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kiwi_axil_rd_arbiter.sv
// AXI-lite read-channel arbiter: N masters onto one slave with round-robin AR grant
// and an in-order ID FIFO that steers each R beat back to the master that issued it.
module kiwi_axil_rd_arbiter #(
    parameter int N_MST    = 2,
    parameter int AW       = 64,
    parameter int DW       = 64,
    parameter int MAX_OUTS = 4,
    localparam int IDW     = (N_MST > 1) ? $clog2(N_MST) : 1,
    localparam int CW      = $clog2(MAX_OUTS + 1),
    localparam int PW      = (MAX_OUTS > 1) ? $clog2(MAX_OUTS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_MST-1:0]    m_arvalid,
    input  logic [N_MST*AW-1:0] m_araddr,
    input  logic [N_MST*3-1:0]  m_arprot,
    output logic [N_MST-1:0]    m_arready,
    output logic [N_MST-1:0]    m_rvalid,
    output logic [DW-1:0]       m_rdata,
    output logic [1:0]          m_rresp,
    input  logic [N_MST-1:0]    m_rready,
    output logic                s_arvalid,
    output logic [AW-1:0]       s_araddr,
    output logic [2:0]          s_arprot,
    input  logic                s_arready,
    input  logic                s_rvalid,
    input  logic [DW-1:0]       s_rdata,
    input  logic [1:0]          s_rresp,
    output logic                s_rready,
    output logic [CW-1:0]       outs_cnt,
    output logic                err_unexp_r
);

    logic           slot_valid_reg;
    logic [AW-1:0]  slot_addr_reg;
    logic [2:0]     slot_prot_reg;
    logic [CW-1:0]  outs_cnt_reg;
    logic [IDW-1:0] rr_ptr_reg;
    logic [PW-1:0]  wr_ptr_reg;
    logic [PW-1:0]  rd_ptr_reg;
    logic           err_reg;
    logic [IDW-1:0] id_mem [MAX_OUTS];

    logic [AW-1:0]  req_addr [N_MST];
    logic [2:0]     req_prot [N_MST];
    logic           grant_found;
    logic [IDW-1:0] grant_idx;
    logic           fifo_full;
    logic           fifo_empty;
    logic           accept_ok;
    logic           accept;
    logic           pop;
    logic [IDW-1:0] head_id;

    assign fifo_full  = (outs_cnt_reg == CW'(MAX_OUTS));
    assign fifo_empty = (outs_cnt_reg == '0);
    // The slot may be refilled in the same cycle it drains; a same-cycle R pop never relieves full.
    assign accept_ok  = (!slot_valid_reg || s_arready) && !fifo_full && !rst;
    assign accept     = accept_ok && grant_found;
    assign head_id    = id_mem[rd_ptr_reg];
    assign pop        = s_rvalid && s_rready;

    // Round-robin search: walk offsets high to low so the closest requester to rr_ptr wins last.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = N_MST - 1; k >= 0; k--) begin
            if (m_arvalid[(int'(rr_ptr_reg) + k) % N_MST]) begin
                grant_found = 1'b1;
                grant_idx   = IDW'((int'(rr_ptr_reg) + k) % N_MST);
            end
        end
    end

    generate
        for (genvar gi = 0; gi < N_MST; gi++) begin : g_mst
            assign req_addr[gi]  = m_araddr[gi*AW +: AW];
            assign req_prot[gi]  = m_arprot[gi*3 +: 3];
            assign m_arready[gi] = accept && (grant_idx == IDW'(gi));
            assign m_rvalid[gi]  = s_rvalid && !fifo_empty && (head_id == IDW'(gi));
        end
    endgenerate

    assign s_rready    = !fifo_empty && m_rready[head_id];
    assign m_rdata     = s_rdata;
    assign m_rresp     = s_rresp;
    assign s_arvalid   = slot_valid_reg;
    assign s_araddr    = slot_addr_reg;
    assign s_arprot    = slot_prot_reg;
    assign outs_cnt    = outs_cnt_reg;
    assign err_unexp_r = err_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_valid_reg <= 1'b0;
            slot_addr_reg  <= '0;
            slot_prot_reg  <= '0;
            outs_cnt_reg   <= '0;
            rr_ptr_reg     <= '0;
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            err_reg        <= 1'b0;
        end else begin
            if (accept) begin
                slot_valid_reg <= 1'b1;
                slot_addr_reg  <= req_addr[grant_idx];
                slot_prot_reg  <= req_prot[grant_idx];
                rr_ptr_reg     <= (grant_idx == IDW'(N_MST - 1)) ? '0 : grant_idx + 1'b1;
                wr_ptr_reg     <= (wr_ptr_reg == PW'(MAX_OUTS - 1)) ? '0 : wr_ptr_reg + 1'b1;
            end else if (s_arready) begin
                slot_valid_reg <= 1'b0;
            end
            if (pop) begin
                rd_ptr_reg <= (rd_ptr_reg == PW'(MAX_OUTS - 1)) ? '0 : rd_ptr_reg + 1'b1;
            end
            outs_cnt_reg <= outs_cnt_reg + CW'(accept) - CW'(pop);
            if (s_rvalid && fifo_empty) begin
                err_reg <= 1'b1;
            end
        end
    end

    // ID storage needs no reset: entries are only read once written.
    always_ff @(posedge clk) begin
        if (accept) begin
            id_mem[wr_ptr_reg] <= grant_idx;
        end
    end

endmodule

// File: tb/tb_kiwi_axil_rd_arbiter.sv
// Bench for kiwi_axil_rd_arbiter: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_kiwi_axil_rd_arbiter;
    localparam int N  = 2;
    localparam int AW = 64;
    localparam int DW = 64;
    localparam int MO = 4;
    localparam int CW = $clog2(MO + 1);

    logic            clk;
    logic            rst;
    logic [N-1:0]    m_arvalid;
    logic [N*AW-1:0] m_araddr;
    logic [N*3-1:0]  m_arprot;
    logic [N-1:0]    m_arready;
    logic [N-1:0]    m_rvalid;
    logic [DW-1:0]   m_rdata;
    logic [1:0]      m_rresp;
    logic [N-1:0]    m_rready;
    logic            s_arvalid;
    logic [AW-1:0]   s_araddr;
    logic [2:0]      s_arprot;
    logic            s_arready;
    logic            s_rvalid;
    logic [DW-1:0]   s_rdata;
    logic [1:0]      s_rresp;
    logic            s_rready;
    logic [CW-1:0]   outs_cnt;
    logic            err_unexp_r;

    kiwi_axil_rd_arbiter #(.N_MST(N), .AW(AW), .DW(DW), .MAX_OUTS(MO)) dut (
        .clk(clk), .rst(rst),
        .m_arvalid(m_arvalid), .m_araddr(m_araddr), .m_arprot(m_arprot), .m_arready(m_arready),
        .m_rvalid(m_rvalid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rready(m_rready),
        .s_arvalid(s_arvalid), .s_araddr(s_araddr), .s_arprot(s_arprot), .s_arready(s_arready),
        .s_rvalid(s_rvalid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rready(s_rready),
        .outs_cnt(outs_cnt), .err_unexp_r(err_unexp_r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    // Reference model state: accepted-but-unanswered master IDs in accept order.
    int           id_q[$];
    int           rr;
    bit           slot_v;
    logic [AW-1:0] slot_a;
    logic [2:0]   slot_p;
    bit           err_m;

    logic [N-1:0] exp_arready;
    logic [N-1:0] exp_rvalid;
    logic         exp_rready;
    int           exp_w;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        n_total++;
        if (act !== expv) $display("FAIL %s: got %h expected %h", nm, act, expv);
        else n_pass++;
    endtask

    task automatic model_reset();
        id_q.delete();
        rr = 0;
        slot_v = 0;
        slot_a = '0;
        slot_p = '0;
        err_m = 0;
    endtask

    task automatic compute_exp();
        bit found;
        bit can;
        found = 0;
        exp_w = 0;
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (rr + k) % N;
            if (!found && m_arvalid[idx]) begin
                found = 1;
                exp_w = idx;
            end
        end
        can = (!slot_v || s_arready) && (id_q.size() < MO);
        exp_arready = (can && found) ? N'(1 << exp_w) : '0;
        if (id_q.size() > 0) begin
            exp_rvalid = s_rvalid ? N'(1 << id_q[0]) : '0;
            exp_rready = m_rready[id_q[0]];
        end else begin
            exp_rvalid = '0;
            exp_rready = 1'b0;
        end
    endtask

    task automatic check_all();
        compute_exp();
        chk("m_arready", 64'(m_arready), 64'(exp_arready));
        chk("m_rvalid", 64'(m_rvalid), 64'(exp_rvalid));
        chk("s_rready", 64'(s_rready), 64'(exp_rready));
        chk("m_rdata", m_rdata, s_rdata);
        chk("m_rresp", 64'(m_rresp), 64'(s_rresp));
        chk("s_arvalid", 64'(s_arvalid), 64'(slot_v));
        chk("s_araddr", s_araddr, slot_a);
        chk("s_arprot", 64'(s_arprot), 64'(slot_p));
        chk("outs_cnt", 64'(outs_cnt), 64'(id_q.size()));
        chk("err_unexp_r", 64'(err_unexp_r), 64'(err_m));
    endtask

    task automatic model_update();
        if (s_rvalid && id_q.size() == 0) err_m = 1;
        if (s_rvalid && exp_rready) void'(id_q.pop_front());
        if (exp_arready != '0) begin
            id_q.push_back(exp_w);
            rr = (exp_w + 1) % N;
            slot_v = 1;
            slot_a = m_araddr[exp_w*AW +: AW];
            slot_p = m_arprot[exp_w*3 +: 3];
        end else if (s_arready) begin
            slot_v = 0;
        end
    endtask

    // Entered just after a falling edge with inputs applied; returns at the next falling edge.
    task automatic cycle();
        #1 check_all();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        m_arvalid = '0; m_araddr = '0; m_arprot = '0; m_rready = '0;
        s_arready = 1'b0; s_rvalid = 1'b0; s_rdata = '0; s_rresp = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        m_arvalid = 2'b11;
        #1;
        chk("rst_m_arready", 64'(m_arready), 64'(0));
        chk("rst_s_arvalid", 64'(s_arvalid), 64'(0));
        chk("rst_s_araddr", s_araddr, 64'(0));
        chk("rst_outs_cnt", 64'(outs_cnt), 64'(0));
        chk("rst_err", 64'(err_unexp_r), 64'(0));
        chk("rst_m_rvalid", 64'(m_rvalid), 64'(0));
        @(posedge clk);
        @(negedge clk);
        model_reset();
        clear_inputs();
        rst = 1'b0;
    endtask

    task automatic random_inputs();
        m_arvalid = N'($urandom);
        m_araddr  = {$urandom, $urandom, $urandom, $urandom};
        m_arprot  = 6'($urandom);
        s_arready = ($urandom_range(0, 3) != 0);
        s_rvalid  = (id_q.size() > 0) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 99) == 0);
        s_rdata   = {$urandom, $urandom};
        s_rresp   = 2'($urandom);
        m_rready  = N'($urandom);
    endtask

    logic [N-1:0] seq [5];
    logic [AW-1:0] held_a;

    initial begin
        rst = 1'b1;
        clear_inputs();
        model_reset();
        seq = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b00};

        // Single master read of 0x1000
        do_reset();
        m_arvalid = 2'b01; m_araddr[63:0] = 64'h1000; m_arprot = 6'b000_010; s_arready = 1'b1;
        #1 chk("single_grant", 64'(m_arready), 64'(2'b01));
        cycle();
        m_arvalid = '0;
        #1 chk("single_s_arvalid", 64'(s_arvalid), 64'(1));
        chk("single_s_araddr", s_araddr, 64'h1000);
        chk("single_outs", 64'(outs_cnt), 64'(1));
        cycle();
        s_rvalid = 1'b1; s_rdata = 64'hDEAD_BEEF; m_rready = 2'b01;
        #1 chk("single_rvalid", 64'(m_rvalid), 64'(2'b01));
        chk("single_rdata", m_rdata, 64'hDEAD_BEEF);
        cycle();
        s_rvalid = 1'b0;
        #1 chk("single_outs_after", 64'(outs_cnt), 64'(0));
        cycle();

        // Both masters requesting: alternating grants until the FIFO fills
        do_reset();
        m_arvalid = 2'b11; s_arready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1 chk("rr_grant", 64'(m_arready), 64'(seq[i]));
            cycle();
        end
        #1 chk("full_outs", 64'(outs_cnt), 64'(4));
        s_rvalid = 1'b1; m_rready = 2'b11;
        #1 chk("full_pop_rvalid", 64'(m_rvalid), 64'(2'b01));
        chk("full_pop_no_accept", 64'(m_arready), 64'(0));
        cycle();
        s_rvalid = 1'b0;
        #1 chk("after_pop_grant", 64'(m_arready), 64'(2'b01));
        chk("after_pop_outs", 64'(outs_cnt), 64'(3));
        cycle();

        // Slave AR stall: slot must hold steady
        do_reset();
        m_arvalid = 2'b01; m_araddr[63:0] = 64'hA5A5_0000_1234_5678;
        cycle();
        held_a = 64'hA5A5_0000_1234_5678;
        m_arvalid = 2'b11; m_araddr = {64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888};
        for (int i = 0; i < 5; i++) begin
            #1 chk("stall_addr", s_araddr, held_a);
            chk("stall_no_grant", 64'(m_arready), 64'(0));
            cycle();
        end
        s_arready = 1'b1;
        #1 chk("stall_release_grant", 64'(m_arready), 64'(2'b10));
        cycle();

        // R backpressure from master 0 (head)
        m_arvalid = '0; s_arready = 1'b0; s_rvalid = 1'b1; m_rready = 2'b00;
        for (int i = 0; i < 3; i++) begin
            #1 chk("bp_s_rready", 64'(s_rready), 64'(0));
            chk("bp_outs", 64'(outs_cnt), 64'(2));
            cycle();
        end
        m_rready = 2'b01;
        #1 chk("bp_release", 64'(s_rready), 64'(1));
        cycle();
        #1 chk("bp_next_head", 64'(m_rvalid), 64'(2'b10));
        chk("bp_outs_after", 64'(outs_cnt), 64'(1));
        cycle();

        // Unexpected R response
        do_reset();
        s_rvalid = 1'b1; m_rready = 2'b11;
        #1 chk("unexp_rvalid", 64'(m_rvalid), 64'(0));
        chk("unexp_rready", 64'(s_rready), 64'(0));
        cycle();
        s_rvalid = 1'b0;
        cycle();
        cycle();
        #1 chk("unexp_sticky", 64'(err_unexp_r), 64'(1));

        // Randomized traffic
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            random_inputs();
            cycle();
        end

        // Asynchronous reset mid-traffic
        random_inputs();
        m_arvalid = 2'b11;
        #2 rst = 1'b1;
        #1 chk("async_rst_arvalid", 64'(s_arvalid), 64'(0));
        chk("async_rst_outs", 64'(outs_cnt), 64'(0));
        chk("async_rst_arready", 64'(m_arready), 64'(0));
        chk("async_rst_rvalid", 64'(m_rvalid), 64'(0));
        chk("async_rst_err", 64'(err_unexp_r), 64'(0));
        chk("async_rst_addr", s_araddr, 64'(0));
        @(posedge clk);
        @(negedge clk);
        model_reset();
        clear_inputs();
        rst = 1'b0;

        for (int i = 0; i < 800; i++) begin
            random_inputs();
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
